// File: rtl/nn_fixed_pkg.sv
// rtl/nn_fixed_pkg.sv - shared FSM encoding and fixed-point helpers for the sequential dense layer
package nn_fixed_pkg;

    // Run-control FSM encoding (IDLE -> MAC -> OUT -> IDLE)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    // Q-format unit at the default fractional width (0x1000 = 1.0)
    localparam int FRAC_DEFAULT = 12;
    localparam int ONE          = 1 << FRAC_DEFAULT;

    // Widest intermediate the helpers operate on; callers sign-extend into this
    localparam int MAX_W = 128;

    // Full product width plus enough guard bits to sum N_IN products and the bias
    function automatic int acc_width(input int bitsize, input int n_in);
        return 2 * bitsize + $clog2(n_in + 1);
    endfunction

    function automatic logic signed [MAX_W-1:0] relu(input logic signed [MAX_W-1:0] v);
        return (v < 0) ? '0 : v;
    endfunction

    // Clamp to the signed range of a bitsize-wide word
    function automatic logic signed [MAX_W-1:0] saturate(input logic signed [MAX_W-1:0] v,
                                                         input int bitsize);
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        hi = (MAX_W'(1) << (bitsize - 1)) - MAX_W'(1);
        lo = ~hi;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one output lane: accumulator init/accumulate and shift/relu/saturate finalise
//   clk, reset : clock and asynchronous active-high reset
//   init       : load accumulator with bias << FRAC
//   acc_en     : add w_k * x_k into the accumulator
//   fin        : register the finalised accumulator into y
//   relu_en    : clamp negative results to zero during fin
//   bias/w_k/x_k : signed operands for this lane
//   y          : registered lane result
module mac_lane
    import nn_fixed_pkg::*;
#(
    parameter int BITSIZE = 16,
    parameter int FRAC    = 12,
    parameter int N_IN    = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic               acc_en,
    input  logic               fin,
    input  logic               relu_en,
    input  logic [BITSIZE-1:0] bias,
    input  logic [BITSIZE-1:0] w_k,
    input  logic [BITSIZE-1:0] x_k,
    output logic [BITSIZE-1:0] y
);

    localparam int AW = acc_width(BITSIZE, N_IN);
    localparam int PW = 2 * BITSIZE;

    logic [AW-1:0]           acc_q, acc_d;
    logic [BITSIZE-1:0]      y_q, y_d;
    logic signed [PW-1:0]    w_ext, x_ext, prod;
    logic signed [AW-1:0]    shifted;
    logic signed [MAX_W-1:0] wide, clipped;

    always_comb begin
        // Operands widened to the product width so the multiply keeps every bit
        w_ext = {{BITSIZE{w_k[BITSIZE-1]}}, w_k};
        x_ext = {{BITSIZE{x_k[BITSIZE-1]}}, x_k};
        prod  = w_ext * x_ext;

        // Floor toward -inf: arithmetic shift, no rounding
        shifted = $signed(acc_q) >>> FRAC;
        wide    = {{(MAX_W-AW){shifted[AW-1]}}, shifted};
        if (relu_en) begin
            wide = relu(wide);
        end
        clipped = saturate(wide, BITSIZE);

        acc_d = acc_q;
        if (init) begin
            acc_d = {{(AW-BITSIZE){bias[BITSIZE-1]}}, bias} << FRAC;
        end else if (acc_en) begin
            acc_d = acc_q + {{(AW-PW){prod[PW-1]}}, prod};
        end

        y_d = y_q;
        if (fin) begin
            y_d = BITSIZE'(clipped);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            acc_q <= acc_d;
            y_q   <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/dense_layer_seq.sv
// rtl/dense_layer_seq.sv - sequential fully-connected layer y = act(W*x + b), one MAC lane per output
//   clk, reset : clock and asynchronous active-high reset
//   start      : begin a run (only accepted in IDLE); relu_en latched alongside
//   w, x, b    : packed weight matrix, input vector and bias vector
//   y          : packed registered results
//   busy       : run in progress (MAC or OUT)
//   done       : single-cycle pulse when y has been updated
module dense_layer_seq
    import nn_fixed_pkg::*;
#(
    parameter int BITSIZE = 16,
    parameter int FRAC    = 12,
    parameter int N_IN    = 6,
    parameter int N_OUT   = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            relu_en,
    input  logic [BITSIZE*N_OUT*N_IN-1:0]   w,
    input  logic [BITSIZE*N_IN-1:0]         x,
    input  logic [BITSIZE*N_OUT-1:0]        b,
    output logic [BITSIZE*N_OUT-1:0]        y,
    output logic                            busy,
    output logic                            done
);

    localparam int KW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N_IN - 1);

    logic [1:0]                      state_q, state_d;
    logic [KW-1:0]                   k_q, k_d;
    logic [BITSIZE*N_OUT*N_IN-1:0]   w_q, w_d;
    logic [BITSIZE*N_IN-1:0]         x_q, x_d;
    logic                            relu_q, relu_d;
    logic                            done_q, done_d;
    logic                            lane_init, lane_acc, lane_fin;
    logic [BITSIZE-1:0]              x_k;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        w_d       = w_q;
        x_d       = x_q;
        relu_d    = relu_q;
        done_d    = 1'b0;
        lane_init = 1'b0;
        lane_acc  = 1'b0;
        lane_fin  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Bias goes straight from the port into the accumulators here,
                // so only w and x need holding copies for the MAC phase.
                if (start) begin
                    w_d       = w;
                    x_d       = x;
                    relu_d    = relu_en;
                    k_d       = '0;
                    lane_init = 1'b1;
                    state_d   = ST_MAC;
                end
            end
            ST_MAC: begin
                lane_acc = 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = ST_OUT;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_OUT: begin
                lane_fin = 1'b1;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            w_q     <= '0;
            x_q     <= '0;
            relu_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            w_q     <= w_d;
            x_q     <= x_d;
            relu_q  <= relu_d;
            done_q  <= done_d;
        end
    end

    // Input element k is shared by every lane
    always_comb begin
        x_k = x_q[int'(k_q)*BITSIZE +: BITSIZE];
    end

    for (genvar o = 0; o < N_OUT; o++) begin : g_lane
        logic [BITSIZE-1:0] w_k;

        always_comb begin
            w_k = w_q[(o*N_IN + int'(k_q))*BITSIZE +: BITSIZE];
        end

        mac_lane #(
            .BITSIZE (BITSIZE),
            .FRAC    (FRAC),
            .N_IN    (N_IN)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .init    (lane_init),
            .acc_en  (lane_acc),
            .fin     (lane_fin),
            .relu_en (relu_q),
            .bias    (b[o*BITSIZE +: BITSIZE]),
            .w_k     (w_k),
            .x_k     (x_k),
            .y       (y[o*BITSIZE +: BITSIZE])
        );
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule

// File: doc/dense_layer_seq.md
# dense_layer_seq

Parametrised, sequential fully-connected layer: y = act(W·x + b) for N_OUT outputs over N_IN inputs in signed Q(BITSIZE−FRAC).FRAC fixed point. It is the generalised successor of the fixed-size encoder layers in the autoencoder datapath. It uses one MAC lane per output, iterates over the inputs one per cycle, and signals completion with a start/done handshake. Results are saturated and can optionally pass through a ReLU.

## Interface

Parameters:
- BITSIZE, 16, width of every weight, input, bias and output word (signed two's complement)
- FRAC, 12, fractional bits (0x1000 = 1.0 at defaults)
- N_IN, 6, input vector length (≥1)
- N_OUT, 2, output vector length (≥1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a computation; honoured only in IDLE
- relu_en  input  1  apply ReLU to this run; latched with start
- w  input  BITSIZE·N_OUT·N_IN  weight row o, column i at [(o·N_IN+i)·BITSIZE +: BITSIZE]
- x  input  BITSIZE·N_IN  element i at [i·BITSIZE +: BITSIZE]
- b  input  BITSIZE·N_OUT  bias o at [o·BITSIZE +: BITSIZE]
- y  output  BITSIZE·N_OUT  result o at [o·BITSIZE +: BITSIZE], registered
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse; y is valid from this cycle onward

## Operation

- FSM states: IDLE → MAC → OUT → IDLE.
- IDLE, start=1: latch w, x, b and relu_en into internal registers. Set acc[o] ← sign-extended b[o] << FRAC and k ← 0. Go to MAC. While latched, input ports may change freely without affecting the run.
- MAC: every cycle, acc[o] ← acc[o] + w[o][k]·x[k] for all o (full 2·BITSIZE signed product) and k ← k+1. Leave for OUT after the cycle with k = N_IN−1.
- OUT: r = acc[o] >>> FRAC (arithmetic shift, floor toward −∞, no rounding). If relu_en and r<0, r = 0. Saturate r to [−2^(BITSIZE−1), 2^(BITSIZE−1)−1]. Register r into y[o]. Pulse done and go to IDLE.
- Accumulator width: 2·BITSIZE + clog2(N_IN+1). No intermediate overflow is possible.
- start while busy (MAC or OUT) is ignored; no queuing.
- y holds its value until the next OUT. done is not sticky.

## Timing

- Reset values: y=0, busy=0, done=0, state=IDLE, acc=0, k=0. Reset takes effect immediately (asynchronous) and releases on the next edge.
- Let E0 be the edge that samples start=1 in IDLE.
  - Edges E1…E_N_IN perform the MACs.
  - Edge E_(N_IN+1) loads y and asserts done.
  - Latency from start-sampling edge to done high: N_IN+1 cycles. Default parameters give 7.
- busy: high from after E0 until after E_(N_IN+1); low in the same cycle done is high.
- Back-to-back: start may be asserted in the done cycle (state is IDLE). It is accepted, giving a throughput of one run per N_IN+1 cycles.
- Reset mid-run aborts the run: no done pulse, and y returns to 0.

## Structure

- Shared package nn_fixed_pkg holds:
  - the FSM state encoding (IDLE/MAC/OUT)
  - the saturate(value, BITSIZE) and relu helpers
  - the accumulator-width calculation
  - the Q-format constant ONE = 1<<FRAC
- Sub-module mac_lane: one instance per output, generated N_OUT times. It holds the accumulator and performs init/accumulate/finalise (shift, ReLU, saturate), driven by the top-level FSM via init, acc_en and k-selected operands.

## Test plan

- Nominal: defaults, w all 0x1000, x all 0x0800, b all 0x0400, relu_en=0 → y[0]=y[1]=0x3400, done exactly 7 cycles after the start edge, busy high for those cycles.
- Saturation: w=x=0x7FFF everywhere, b=0x7FFF → y=0x7FFF. w=0x8000, x=0x7FFF, b=0x8000 → y=0x8000.
- ReLU: w all 0xF000 (−1.0), x all 0x0800, b=0 → relu_en=0 gives 0xD000 (−3.0). relu_en=1 gives 0x0000. A positive result is unchanged by relu_en.
- Truncation: N_IN=1, w=0x0001, x=0x0001, b=0 → y=0x0000. w=0xFFFF, x=0x0001 → y=0xFFFF (floor).
- Handshake: pulse start again and change x/w during MAC → no effect on the result, a single done. Start in the done cycle → second run accepted, second done exactly N_IN+1 cycles later.
- Reset mid-run: assert reset during the 3rd MAC cycle → y/busy/done go to 0 immediately, with no done pulse. After release, a nominal run yields 0x3400.
